game_flow_sequencer: RTL and testbench
======================================

# game_flow_sequencer

Frame-rate game controller that sequences a round: idle/attract, play, post-hit invulnerability and game-over. It consumes the per-frame collision flags from the collision detector and the `frame_end` strobe from the sync generator. It owns the player's lives and score, and issues the entity-reset, sound-trigger and dragon-grow strobes to the player, dragon, APU and PPU blocks, replacing the hard-wired `playerLives` and direct collision-to-APU wiring in the top level.

## Interface
Parameters:
- START_LIVES, 3: lives loaded on reset and on entering IDLE; legal range 1-3.
- INVULN_FRAMES, 60: frames spent in HIT after losing a life; legal range 1-255.
- OVER_FRAMES, 180: frames spent in OVER before returning to IDLE; legal range 1-255.

Ports:
- clk  in  1  system pixel clock; single clock domain.
- reset  in  1  synchronous, active-high; tie to ~rst_n.
- frame_end  in  1  one-cycle strobe, once per frame, from the sync generator.
- start_btn  in  1  level; the attack button.
- player_dragon_hit  in  1  level, valid in the frame_end cycle.
- sword_dragon_hit  in  1  level, valid in the frame_end cycle.
- sheep_dragon_hit  in  1  level, valid in the frame_end cycle.
- state  out  2  00 IDLE, 01 PLAY, 10 HIT, 11 OVER.
- lives  out  2  remaining lives; feeds the heart entity array field.
- score  out  8  dragon hits scored; saturates at 255.
- game_active  out  1  high in PLAY and HIT.
- player_visible  out  1  sprite enable for the player entity (flashes in HIT).
- entity_reset  out  1  one-cycle strobe; re-initialises player, dragon and sheep.
- snare_trigger  out  1  one-cycle strobe to the APU.
- dragon_grow  out  1  one-cycle strobe to the DragonBody lengthUpdate logic.

## Operation
- All inputs are sampled only on the clk edge where frame_end=1. All other cycles hold state; strobe outputs are 0.
- start_prev register: captures start_btn on every frame_end. A start event is start_btn=1 with start_prev=0, i.e. a rising edge at frame granularity.
- Timer: 8-bit down-counter that decrements on each frame_end in HIT and OVER.
- IDLE:
  - lives=START_LIVES, score=0.
  - On a start event: go to PLAY, pulse entity_reset, clear score.
- PLAY, evaluated at frame_end:
  - Priority 1, player_dragon_hit=1:
    - Decrement lives.
    - If lives was 1: go to OVER, lives=0, timer=OVER_FRAMES.
    - Otherwise: go to HIT, timer=INVULN_FRAMES.
    - sword_dragon_hit and sheep_dragon_hit are ignored in that frame.
  - Otherwise sword_dragon_hit and sheep_dragon_hit are handled independently and may both fire in one frame:
    - sword_dragon_hit: score+1, saturating at 255; snare_trigger strobe.
    - sheep_dragon_hit: dragon_grow strobe.
- HIT:
  - player_dragon_hit is ignored.
  - Sword and sheep handling is as in PLAY.
  - When timer=1 at frame_end: go to PLAY, timer=0; no entity_reset.
  - Otherwise timer-1.
- OVER:
  - All collision inputs and start_btn are ignored; score is held for display.
  - When timer=1 at frame_end: go to IDLE and load lives=START_LIVES.
- player_visible: ~timer[2] in HIT (toggles every 4 frames); 1 in all other states.
- game_active is a combinational decode of the state register.

## Timing
- Reset values:
  - state=IDLE, lives=START_LIVES, score=0, timer=0.
  - start_prev=1, so a button held through reset does not start a game.
  - game_active=0, player_visible=1, all strobes 0.
- Reset overrides frame_end in the same cycle. Reset mid-round returns to IDLE with no entity_reset strobe.
- Latency: outputs are registered. state, lives, score and strobes change on the edge where frame_end=1 and are visible the following cycle.
- Strobes are exactly one clk cycle wide and occur at most once per frame.
- HIT lasts exactly INVULN_FRAMES frame_end events. OVER lasts exactly OVER_FRAMES frame_end events.
- score saturation: at 255, a sword hit still strobes snare_trigger; score stays 255.

## Test plan
- Reset with start_btn=1 held through 3 frames → remains IDLE. Release, then press → PLAY on the next frame_end; entity_reset high for 1 cycle; score=0; lives=3.
- In PLAY, player_dragon_hit for one frame → state=HIT, lives=2. Hits during the next 59 frames are ignored; PLAY resumes after exactly 60 frame_end events. player_visible toggles every 4 frames during HIT.
- Three separated player hits → lives 3→2→1→0; state=OVER after the third. After 180 frames → IDLE with lives=3; score is retained until the next start.
- player_dragon_hit, sword_dragon_hit and sheep_dragon_hit together in one PLAY frame → lives-1, HIT; no snare_trigger, no dragon_grow, score unchanged.
- sword_dragon_hit and sheep_dragon_hit together in PLAY and also in HIT → score+1, with snare_trigger and dragon_grow in the same cycle. Preload score to 255 → score stays 255 and snare_trigger still fires.
- Collision inputs held high on non-frame_end cycles only → no state change. Reset asserted mid-HIT → IDLE with lives=3 next cycle.

Source files
------------

// File: rtl/game_flow_sequencer.sv
// Frame-rate round sequencer: IDLE/attract, PLAY, post-hit invulnerability (HIT) and OVER.
// Owns lives and score and issues one-cycle entity-reset, snare and dragon-grow strobes.
module game_flow_sequencer #(
    parameter int START_LIVES   = 3,
    parameter int INVULN_FRAMES = 60,
    parameter int OVER_FRAMES   = 180
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       frame_end,
    input  logic       start_btn,
    input  logic       player_dragon_hit,
    input  logic       sword_dragon_hit,
    input  logic       sheep_dragon_hit,
    output logic [1:0] state,
    output logic [1:0] lives,
    output logic [7:0] score,
    output logic       game_active,
    output logic       player_visible,
    output logic       entity_reset,
    output logic       snare_trigger,
    output logic       dragon_grow
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_PLAY = 2'b01,
        ST_HIT  = 2'b10,
        ST_OVER = 2'b11
    } state_t;

    localparam logic [1:0] LIVES_INIT  = 2'(START_LIVES);
    localparam logic [7:0] INVULN_INIT = 8'(INVULN_FRAMES);
    localparam logic [7:0] OVER_INIT   = 8'(OVER_FRAMES);

    state_t     state_reg;
    logic [1:0] lives_reg;
    logic [7:0] score_reg;
    logic [7:0] timer_reg;
    logic       start_prev_reg;
    logic       entity_reset_reg;
    logic       snare_trigger_reg;
    logic       dragon_grow_reg;
    logic [7:0] score_next;
    logic       start_event;

    assign score_next  = (score_reg == 8'hFF) ? score_reg : score_reg + 8'd1;
    assign start_event = start_btn & ~start_prev_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg         <= ST_IDLE;
            lives_reg         <= LIVES_INIT;
            score_reg         <= 8'd0;
            timer_reg         <= 8'd0;
            // Held high so a button pressed through reset is not a start event.
            start_prev_reg    <= 1'b1;
            entity_reset_reg  <= 1'b0;
            snare_trigger_reg <= 1'b0;
            dragon_grow_reg   <= 1'b0;
        end else begin
            entity_reset_reg  <= 1'b0;
            snare_trigger_reg <= 1'b0;
            dragon_grow_reg   <= 1'b0;
            if (frame_end) begin
                start_prev_reg <= start_btn;
                case (state_reg)
                    ST_IDLE: begin
                        lives_reg <= LIVES_INIT;
                        if (start_event) begin
                            state_reg        <= ST_PLAY;
                            entity_reset_reg <= 1'b1;
                            score_reg        <= 8'd0;
                        end
                    end
                    ST_PLAY: begin
                        if (player_dragon_hit) begin
                            lives_reg <= lives_reg - 2'd1;
                            if (lives_reg == 2'd1) begin
                                state_reg <= ST_OVER;
                                timer_reg <= OVER_INIT;
                            end else begin
                                state_reg <= ST_HIT;
                                timer_reg <= INVULN_INIT;
                            end
                        end else begin
                            if (sword_dragon_hit) begin
                                score_reg         <= score_next;
                                snare_trigger_reg <= 1'b1;
                            end
                            dragon_grow_reg <= sheep_dragon_hit;
                        end
                    end
                    ST_HIT: begin
                        // Invulnerable: player hits ignored, scoring still live.
                        if (sword_dragon_hit) begin
                            score_reg         <= score_next;
                            snare_trigger_reg <= 1'b1;
                        end
                        dragon_grow_reg <= sheep_dragon_hit;
                        if (timer_reg == 8'd1) begin
                            state_reg <= ST_PLAY;
                            timer_reg <= 8'd0;
                        end else begin
                            timer_reg <= timer_reg - 8'd1;
                        end
                    end
                    ST_OVER: begin
                        if (timer_reg == 8'd1) begin
                            state_reg <= ST_IDLE;
                            lives_reg <= LIVES_INIT;
                            timer_reg <= 8'd0;
                        end else begin
                            timer_reg <= timer_reg - 8'd1;
                        end
                    end
                endcase
            end
        end
    end

    assign state          = state_reg;
    assign lives          = lives_reg;
    assign score          = score_reg;
    assign game_active    = (state_reg == ST_PLAY) || (state_reg == ST_HIT);
    assign player_visible = (state_reg != ST_HIT) || !timer_reg[2];
    assign entity_reset   = entity_reset_reg;
    assign snare_trigger  = snare_trigger_reg;
    assign dragon_grow    = dragon_grow_reg;

endmodule

// File: tb/tb_game_flow_sequencer.sv
// Bench for game_flow_sequencer: directed round scenarios plus randomized frames,
// checked every cycle against a frame-level behavioural model.
module tb_game_flow_sequencer;

    localparam int SL  = 3;
    localparam int INV = 60;
    localparam int OV  = 180;
    localparam int S_IDLE = 0, S_PLAY = 1, S_HIT = 2, S_OVER = 3;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       frame_end = 1'b0;
    logic       start_btn = 1'b1;
    logic       player_dragon_hit = 1'b0;
    logic       sword_dragon_hit = 1'b0;
    logic       sheep_dragon_hit = 1'b0;
    logic [1:0] state;
    logic [1:0] lives;
    logic [7:0] score;
    logic       game_active;
    logic       player_visible;
    logic       entity_reset;
    logic       snare_trigger;
    logic       dragon_grow;

    game_flow_sequencer #(
        .START_LIVES  (SL),
        .INVULN_FRAMES(INV),
        .OVER_FRAMES  (OV)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .frame_end        (frame_end),
        .start_btn        (start_btn),
        .player_dragon_hit(player_dragon_hit),
        .sword_dragon_hit (sword_dragon_hit),
        .sheep_dragon_hit (sheep_dragon_hit),
        .state            (state),
        .lives            (lives),
        .score            (score),
        .game_active      (game_active),
        .player_visible   (player_visible),
        .entity_reset     (entity_reset),
        .snare_trigger    (snare_trigger),
        .dragon_grow      (dragon_grow)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    bit check_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input int exp);
        n_checks++;
        if (act !== 32'(exp)) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Frame-level model: mode, lives, score and frames left in the timed phases.
    int m_mode, m_lives, m_score, m_left;
    bit m_prev;
    bit e_entity, e_snare, e_grow;

    always @(posedge clk) begin
        e_entity = 0;
        e_snare  = 0;
        e_grow   = 0;
        if (reset) begin
            m_mode = S_IDLE; m_lives = SL; m_score = 0; m_left = 0; m_prev = 1;
        end else if (frame_end) begin
            bit start_ev;
            start_ev = start_btn && !m_prev;
            m_prev = start_btn;
            if (m_mode == S_IDLE) begin
                m_lives = SL;
                if (start_ev) begin
                    m_mode = S_PLAY; e_entity = 1; m_score = 0;
                end
            end else if (m_mode == S_OVER) begin
                m_left = m_left - 1;
                if (m_left == 0) begin
                    m_mode = S_IDLE; m_lives = SL;
                end
            end else if (m_mode == S_PLAY && player_dragon_hit) begin
                m_lives = m_lives - 1;
                m_mode  = (m_lives == 0) ? S_OVER : S_HIT;
                m_left  = (m_lives == 0) ? OV : INV;
            end else begin
                if (sword_dragon_hit) begin
                    e_snare = 1;
                    if (m_score < 255) m_score = m_score + 1;
                end
                e_grow = sheep_dragon_hit;
                if (m_mode == S_HIT) begin
                    m_left = m_left - 1;
                    if (m_left == 0) m_mode = S_PLAY;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (check_en) begin
            check("state", 32'(state), m_mode);
            check("lives", 32'(lives), m_lives);
            check("score", 32'(score), m_score);
            check("game_active", 32'(game_active), int'(m_mode == S_PLAY || m_mode == S_HIT));
            check("player_visible", 32'(player_visible),
                  int'(m_mode != S_HIT || ((m_left / 4) % 2) == 0));
            check("entity_reset", 32'(entity_reset), int'(e_entity));
            check("snare_trigger", 32'(snare_trigger), int'(e_snare));
            check("dragon_grow", 32'(dragon_grow), int'(e_grow));
        end
    end

    // One frame: frame_end cycle with the given inputs, then a gap cycle of random noise.
    task automatic do_frame(input bit s, input bit p, input bit w, input bit h);
        @(negedge clk);
        frame_end = 1; start_btn = s; player_dragon_hit = p;
        sword_dragon_hit = w; sheep_dragon_hit = h;
        @(negedge clk);
        frame_end = 0;
        start_btn = 1'($urandom); player_dragon_hit = 1'($urandom);
        sword_dragon_hit = 1'($urandom); sheep_dragon_hit = 1'($urandom);
    endtask

    task automatic do_reset(input int cycles);
        @(negedge clk);
        reset = 1; frame_end = 1; player_dragon_hit = 1; start_btn = 1;
        repeat (cycles) @(negedge clk);
        reset = 0; frame_end = 0;
    endtask

    task automatic run_until(input int target, input bit s, input bit p, input bit w,
                             input bit h, output int frames);
        frames = 0;
        while (32'(state) != 32'(target) && frames < 400) begin
            do_frame(s, p, w, h);
            frames++;
        end
    endtask

    initial begin
        int n;
        repeat (3) @(negedge clk);
        check_en = 1;
        check("reset_state", 32'(state), S_IDLE);
        check("reset_lives", 32'(lives), 3);
        check("reset_visible", 32'(player_visible), 1);
        reset = 0;

        repeat (3) do_frame(1, 0, 0, 0);
        check("held_start_idle", 32'(state), S_IDLE);
        $display("start held through reset: state=%0d", state);

        do_frame(0, 0, 0, 0);
        do_frame(1, 0, 0, 0);
        check("start_play", 32'(state), S_PLAY);
        check("start_entity_reset", 32'(entity_reset), 1);
        check("start_lives", 32'(lives), 3);
        check("start_score", 32'(score), 0);
        @(negedge clk);
        check("entity_reset_width", 32'(entity_reset), 0);
        $display("start: state=%0d lives=%0d score=%0d", state, lives, score);

        do_frame(0, 1, 0, 0);
        check("hit1_state", 32'(state), S_HIT);
        check("hit1_lives", 32'(lives), 2);
        check("hit1_visible", 32'(player_visible), 0);
        repeat (4) do_frame(0, 1, 0, 0);
        check("hit1_visible_after4", 32'(player_visible), 1);
        run_until(S_PLAY, 0, 1, 0, 0, n);
        check("hit1_frames", 32'(n + 4), INV);
        check("hit1_lives_kept", 32'(lives), 2);
        $display("hit1: HIT lasted %0d frames, lives=%0d", n + 4, lives);

        do_frame(0, 1, 1, 1);
        check("hit2_lives", 32'(lives), 1);
        check("hit2_no_snare", 32'(snare_trigger), 0);
        check("hit2_no_grow", 32'(dragon_grow), 0);
        check("hit2_score", 32'(score), 0);
        do_frame(0, 0, 1, 1);
        check("hit_sword_score", 32'(score), 1);
        check("hit_sword_snare", 32'(snare_trigger), 1);
        check("hit_sheep_grow", 32'(dragon_grow), 1);
        run_until(S_PLAY, 0, 0, 0, 0, n);
        check("hit2_frames", 32'(n), INV - 1);
        do_frame(0, 0, 1, 1);
        check("play_both_score", 32'(score), 2);
        check("play_both_snare", 32'(snare_trigger), 1);
        check("play_both_grow", 32'(dragon_grow), 1);
        $display("hit2 and scoring: lives=%0d score=%0d", lives, score);

        do_frame(0, 1, 0, 0);
        check("hit3_over", 32'(state), S_OVER);
        check("hit3_lives", 32'(lives), 0);
        run_until(S_IDLE, 1, 1, 1, 1, n);
        check("over_frames", 32'(n), OV);
        check("over_idle_lives", 32'(lives), 3);
        check("over_score_kept", 32'(score), 2);
        $display("game over: OVER lasted %0d frames, score=%0d", n, score);

        do_frame(0, 0, 0, 0);
        do_frame(1, 0, 0, 0);
        check("restart_score", 32'(score), 0);
        repeat (260) do_frame(0, 0, 1, 0);
        check("sat_score", 32'(score), 255);
        check("sat_snare", 32'(snare_trigger), 1);
        $display("saturation: score=%0d snare=%0d", score, snare_trigger);

        do_frame(0, 1, 0, 0);
        check("pre_reset_hit", 32'(state), S_HIT);
        do_reset(1);
        check("midhit_reset_state", 32'(state), S_IDLE);
        check("midhit_reset_lives", 32'(lives), 3);
        check("midhit_reset_entity", 32'(entity_reset), 0);
        $display("reset mid-HIT: state=%0d lives=%0d", state, lives);

        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 799) == 0) do_reset(1 + $urandom_range(0, 2));
            do_frame(1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 7) == 0),
                     1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 3) == 0));
        end
        $display("random frames: final state=%0d lives=%0d score=%0d", state, lives, score);

        @(negedge clk);
        check_en = 0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
